// File: rtl/ps2_key_translator_if.sv
// PS/2 keyboard link plus the translated command outputs.
// master: keyboard / test side, drives the raw PS/2 lines.
// slave : ps2_key_translator, samples the lines and drives the command bus.
interface ps2_key_translator_if;
    logic       ps2Clk;
    logic       ps2Data;
    logic [7:0] inCode;
    logic       codeValid;
    logic       frameErr;

    modport master (
        output ps2Clk, ps2Data,
        input  inCode, codeValid, frameErr
    );

    modport slave (
        input  ps2Clk, ps2Data,
        output inCode, codeValid, frameErr
    );
endinterface

// File: rtl/ps2_key_translator.sv
// PS/2 keyboard front end for inputDecode.
// Receives PS/2 frames, checks parity and stop bit, resolves the E0/F0 prefixes
// and turns make codes of the mapped keys into one-cycle command pulses on inCode.
// inCode rests at IDLE_CODE whenever no command is issued.
// Optional build macro REPEAT_SUPPRESS_EN: when defined, typematic repeat makes of
// the currently held key produce no output.
module ps2_key_translator #(
    parameter int         FILTER_LEN     = 4,
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter logic [7:0] IDLE_CODE      = 8'hFF
) (
    input  logic                clock_i,
    input  logic                reset_i,
    ps2_key_translator_if.slave bus_io
);

    localparam int           FW        = $clog2(FILTER_LEN) + 1;
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam int           TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    // Synchronisers and ps2Clk filter
    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          filt_lvl_q;
    logic [FW-1:0] filt_cnt_q;
    logic          fall_q;
    logic          bit_q;

    // Frame receiver
    logic [1:0]    state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          byte_ok_q, byte_ok_d;
    logic          abort_q, abort_d;
    logic          frame_err_q, frame_err_d;

    // Prefix flags and command output
    logic          ext_q, ext_d;
    logic          brk_q, brk_d;
    logic [7:0]    in_code_q, in_code_d;
    logic          code_valid_q, code_valid_d;
    logic [8:0]    key;
    logic [4:0]    key_map;
`ifdef REPEAT_SUPPRESS_EN
    logic [8:0]    held_q, held_d;
    logic          held_vld_q, held_vld_d;
`endif

    // {hit, command} for a 9-bit key {ext, scan code}
    function automatic logic [4:0] map_key(input logic [8:0] k);
        case (k)
            9'h016:  return 5'h11;
            9'h01E:  return 5'h12;
            9'h026:  return 5'h13;
            9'h02D:  return 5'h14;
            9'h034:  return 5'h15;
            9'h032:  return 5'h16;
            9'h175:  return 5'h17;
            9'h172:  return 5'h18;
            9'h16B:  return 5'h19;
            9'h174:  return 5'h1A;
            9'h079:  return 5'h1B;
            9'h07B:  return 5'h1C;
            9'h02B:  return 5'h1D;
            default: return 5'h00;
        endcase
    endfunction

    // Two-flop synchronisers; lines idle high
    always_ff @(posedge clock_i or posedge reset_i) begin
        // NOTE: non-blocking assignments keep each flop sampling the previous value of its neighbour.
        if (reset_i) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= bus_io.ps2Clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= bus_io.ps2Data;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Accept a ps2Clk level only after FILTER_LEN consecutive differing samples;
    // flag the accepted 1->0 edge together with the data bit seen at that moment
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            filt_lvl_q <= 1'b1;
            filt_cnt_q <= '0;
            fall_q     <= 1'b0;
            bit_q      <= 1'b1;
        end else begin
            fall_q <= 1'b0;
            if (clk_s2_q == filt_lvl_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FILT_LAST) begin
                filt_lvl_q <= clk_s2_q;
                filt_cnt_q <= '0;
                fall_q     <= ~clk_s2_q;
                bit_q      <= dat_s2_q;
            end else begin
                filt_cnt_q <= filt_cnt_q + FW'(1);
            end
        end
    end

    // Frame FSM, bit collection and inter-edge timeout
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        byte_ok_d   = 1'b0;
        abort_d     = 1'b0;
        frame_err_d = 1'b0;

        if (state_q == S_IDLE || fall_q) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_LAST) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end else begin
            to_cnt_d = to_cnt_q;
        end

        if (fall_q) begin
            case (state_q)
                S_IDLE: begin
                    if (!bit_q) begin
                        state_d   = S_DATA;
                        bit_cnt_d = 4'd0;
                    end
                end
                S_DATA: begin
                    shift_d = {bit_q, shift_q[7:1]};
                    if (bit_cnt_q == 4'd7) begin
                        state_d = S_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                S_PARITY: begin
                    parity_d = bit_q;
                    state_d  = S_STOP;
                end
                default: begin
                    state_d = S_IDLE;
                    if (bit_q && (^{shift_q, parity_q})) begin
                        byte_ok_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            endcase
        end else if (state_q != S_IDLE && to_cnt_q == TO_LAST) begin
            state_d     = S_IDLE;
            abort_d     = 1'b1;
            frame_err_d = 1'b1;
        end
    end

    // Frame receiver registers
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            parity_q    <= 1'b0;
            to_cnt_q    <= '0;
            byte_ok_q   <= 1'b0;
            abort_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            to_cnt_q    <= to_cnt_d;
            byte_ok_q   <= byte_ok_d;
            abort_q     <= abort_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Prefix resolution and translation of a completed byte into a command pulse
    always_comb begin
        ext_d        = ext_q;
        brk_d        = brk_q;
        in_code_d    = IDLE_CODE;
        code_valid_d = 1'b0;
`ifdef REPEAT_SUPPRESS_EN
        held_d       = held_q;
        held_vld_d   = held_vld_q;
`endif
        key     = {ext_q, shift_q};
        key_map = map_key(key);

        if (abort_q) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_ok_q) begin
            if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (brk_q) begin
`ifdef REPEAT_SUPPRESS_EN
                    if (held_vld_q && held_q == key) begin
                        held_vld_d = 1'b0;
                    end
`endif
                end else if (key_map[4]) begin
`ifdef REPEAT_SUPPRESS_EN
                    if (!(held_vld_q && held_q == key)) begin
                        in_code_d    = {4'h0, key_map[3:0]};
                        code_valid_d = 1'b1;
                    end
                    held_d     = key;
                    held_vld_d = 1'b1;
`else
                    in_code_d    = {4'h0, key_map[3:0]};
                    code_valid_d = 1'b1;
`endif
                end
            end
        end
    end

    // Flag, held-key and output registers
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            in_code_q    <= IDLE_CODE;
            code_valid_q <= 1'b0;
`ifdef REPEAT_SUPPRESS_EN
            held_q       <= 9'h000;
            held_vld_q   <= 1'b0;
`endif
        end else begin
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            in_code_q    <= in_code_d;
            code_valid_q <= code_valid_d;
`ifdef REPEAT_SUPPRESS_EN
            held_q       <= held_d;
            held_vld_q   <= held_vld_d;
`endif
        end
    end

    assign bus_io.inCode    = in_code_q;
    assign bus_io.codeValid = code_valid_q;
    assign bus_io.frameErr  = frame_err_q;

endmodule

// File: tb/tb_ps2_key_translator.sv
// Bench for ps2_key_translator: drives PS/2 frames, collects every command pulse
// and frame error, and compares them with a byte-level keyboard model.
module tb_ps2_key_translator;

    localparam int         FILTER_LEN = 4;
    localparam int         TIMEOUT    = 200;
    localparam int         HALF       = 10;
    localparam logic [7:0] IDLE       = 8'hFF;
`ifdef REPEAT_SUPPRESS_EN
    localparam bit         SUPP       = 1'b1;
`else
    localparam bit         SUPP       = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_key_translator_if bus ();

    ps2_key_translator #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT),
        .IDLE_CODE      (IDLE)
    ) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus_io  (bus)
    );

    int tests = 0;
    int fails = 0;

    int obs_q[$];
    int exp_q[$];
    int obs_err = 0;
    int exp_err = 0;
    int viol    = 0;

    int keymap[int];
    int m_ext  = 0;
    int m_brk  = 0;
    int m_held = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Output monitor: records pulses, counts errors, flags protocol violations
    initial begin
        logic prev_valid, prev_err;
        prev_valid = 1'b0;
        prev_err   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
                prev_err   = 1'b0;
            end else begin
                if (bus.codeValid === 1'b1) begin
                    obs_q.push_back(int'(bus.inCode));
                    if (prev_valid) viol++;
                end else if (bus.inCode !== IDLE || bus.codeValid !== 1'b0) begin
                    viol++;
                end
                if (bus.frameErr === 1'b1) begin
                    obs_err++;
                    if (prev_err) viol++;
                end else if (bus.frameErr !== 1'b0) begin
                    viol++;
                end
                prev_valid = (bus.codeValid === 1'b1);
                prev_err   = (bus.frameErr === 1'b1);
            end
        end
    end

    // Keyboard model: one received byte at a time
    task automatic model_byte(input int b);
        int k;
        if (b == 'hE0) begin
            m_ext = 1;
        end else if (b == 'hF0) begin
            m_brk = 1;
        end else begin
            k = m_ext * 256 + b;
            if (m_brk) begin
                if (k == m_held) m_held = -1;
            end else if (keymap.exists(k)) begin
                if (!SUPP || k != m_held) exp_q.push_back(keymap[k]);
                m_held = k;
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic model_reset();
        m_ext  = 0;
        m_brk  = 0;
        m_held = -1;
    endtask

    // Drive the first nbits of an 11-bit frame; data changes while ps2Clk is high
    task automatic send_frame(input logic [7:0] b, input int nbits, input bit bad_par, input bit bad_stop);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            bus.ps2Data = f[i];
            tick(HALF);
            bus.ps2Clk = 1'b0;
            tick(HALF);
            bus.ps2Clk = 1'b1;
        end
        bus.ps2Data = 1'b1;
        tick(HALF * 3);
    endtask

    task automatic xmit(input logic [7:0] b, input bit bad_par = 1'b0, input bit bad_stop = 1'b0);
        send_frame(b, 11, bad_par, bad_stop);
        if (bad_par || bad_stop) exp_err++;
        else model_byte(int'(b));
    endtask

    task automatic compare_step(input string name);
        int n;
        tick(20);
        check({name, " count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s code%0d", name, i), obs_q[i], exp_q[i]);
        end
        check({name, " frameErr"}, obs_err, exp_err);
        check({name, " protocol"}, viol, 0);
        obs_q.delete();
        exp_q.delete();
        obs_err = 0;
        exp_err = 0;
        viol    = 0;
    endtask

    initial begin
        logic [7:0] pool [17];
        int         r;

        keymap['h016] = 1;  keymap['h01E] = 2;  keymap['h026] = 3;
        keymap['h02D] = 4;  keymap['h034] = 5;  keymap['h032] = 6;
        keymap['h175] = 7;  keymap['h172] = 8;  keymap['h16B] = 9;
        keymap['h174] = 10; keymap['h079] = 11; keymap['h07B] = 12;
        keymap['h02B] = 13;
        pool = '{8'h16, 8'h1E, 8'h26, 8'h2D, 8'h34, 8'h32, 8'h75, 8'h72, 8'h6B,
                 8'h74, 8'h79, 8'h7B, 8'h2B, 8'hE0, 8'hF0, 8'h1C, 8'h5A};

        // Reset state
        bus.ps2Clk  = 1'b1;
        bus.ps2Data = 1'b1;
        rst = 1'b1;
        tick(5);
        check("reset inCode", bus.inCode, IDLE);
        check("reset codeValid", bus.codeValid, 1'b0);
        check("reset frameErr", bus.frameErr, 1'b0);
        rst = 1'b0;
        model_reset();
        tick(10);
        check("post-reset inCode", bus.inCode, IDLE);

        // Single make of R
        xmit(8'h2D);
        check("t1 direct", (obs_q.size() == 1) ? obs_q[0] : -1, 4);
        compare_step("t1");

        // Extended up: make, release, then plain 75 is keypad 8 (unmapped)
        xmit(8'hE0); xmit(8'h75);
        xmit(8'hE0); xmit(8'hF0); xmit(8'h75);
        xmit(8'h75);
        check("t2 direct", (obs_q.size() == 1) ? obs_q[0] : -1, 7);
        compare_step("t2");

        // Bad parity, then a good frame
        xmit(8'h16, 1'b1, 1'b0);
        xmit(8'h1E);
        compare_step("t3");

        // Bad stop bit, then a good frame
        xmit(8'h26, 1'b0, 1'b1);
        xmit(8'h26);
        compare_step("t3b");

        // Pending E0 then truncated frame: timeout aborts and clears the prefix
        xmit(8'hE0);
        send_frame(8'h2B, 5, 1'b0, 1'b0);
        tick(TIMEOUT + 50);
        exp_err++;
        m_ext = 0;
        m_brk = 0;
        xmit(8'h75);
        xmit(8'h2B);
        compare_step("t4");

        // Short low glitch on ps2Clk with data low must not start a frame
        bus.ps2Data = 1'b0;
        tick(3);
        bus.ps2Clk = 1'b0;
        tick(2);
        bus.ps2Clk = 1'b1;
        tick(3);
        bus.ps2Data = 1'b1;
        tick(TIMEOUT + 50);
        compare_step("glitch");

        // Typematic repeats of kp+
        xmit(8'h79); xmit(8'h79); xmit(8'h79);
        xmit(8'hF0); xmit(8'h79);
        check("t5 pulses", obs_q.size(), SUPP ? 1 : 3);
        compare_step("t5");

        // Reset in the middle of frame 34
        send_frame(8'h34, 5, 1'b0, 1'b0);
        rst = 1'b1;
        tick(3);
        check("t6 rst inCode", bus.inCode, IDLE);
        check("t6 rst codeValid", bus.codeValid, 1'b0);
        check("t6 rst frameErr", bus.frameErr, 1'b0);
        bus.ps2Clk  = 1'b1;
        bus.ps2Data = 1'b1;
        rst = 1'b0;
        model_reset();
        obs_q.delete();
        obs_err = 0;
        viol    = 0;
        tick(10);
        xmit(8'h32);
        compare_step("t6");

        // Random byte stream with occasional corrupted frames
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < 10; i++) begin
                r = int'($urandom_range(0, 19));
                xmit(pool[$urandom_range(0, 16)], r == 0, r == 1);
            end
            compare_step($sformatf("rand%0d", blk));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
